// File: rtl/lcd_cfah_pkg.sv
// Shared types and constants for the CFAH1602 LCD bus responder:
// FSM states, instruction decode constants and address arithmetic.
package lcd_cfah_pkg;

   localparam int C_ADDR_W = 7;

   localparam logic [7:0] C_INSTR_CLEAR      = 8'h01;
   localparam logic [7:0] C_INSTR_HOME       = 8'h02;
   localparam logic [7:0] C_INSTR_HOME_MASK  = 8'hFE;
   localparam logic [7:0] C_INSTR_ENTRY      = 8'h04;
   localparam logic [7:0] C_INSTR_ENTRY_MASK = 8'hFC;
   localparam int         C_INSTR_SET_DDRAM_BIT = 7;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2
   } state_t;

   // The address counter wraps modulo 128 in both directions.
   function automatic logic [C_ADDR_W-1:0] addr_step(input logic [C_ADDR_W-1:0] addr,
                                                     input logic inc);
      if (inc) begin
         addr_step = addr + 7'd1;
      end else begin
         addr_step = addr - 7'd1;
      end
   endfunction

endpackage

// File: rtl/lcd_cfah_bus_sync.sv
// Synchronizer for the asynchronous LCD bus pins {rs, rw, en, data} with
// registered EN rise/fall pulses aligned to the matching rs/rw/data sample.
module lcd_cfah_bus_sync #(
   parameter int G_SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rs,
   input  logic       rw,
   input  logic       en,
   input  logic [7:0] data,
   output logic       rs_q,
   output logic       rw_q,
   output logic [7:0] data_q,
   output logic       en_rise,
   output logic       en_fall
);

   logic [G_SYNC_STAGES-1:0][10:0] stage_r;
   logic [10:0] last_s;
   logic        en_prev_r;
   logic        rise_r;
   logic        fall_r;
   logic        rs_r;
   logic        rw_r;
   logic [7:0]  data_r;

   assign last_s = stage_r[G_SYNC_STAGES-1];

   // Synchronizer chain followed by the edge detector on the last stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         stage_r   <= '0;
         en_prev_r <= 1'b0;
         rise_r    <= 1'b0;
         fall_r    <= 1'b0;
         rs_r      <= 1'b0;
         rw_r      <= 1'b0;
         data_r    <= 8'h00;
      end else begin
         stage_r   <= {stage_r[G_SYNC_STAGES-2:0], {rs, rw, en, data}};
         en_prev_r <= last_s[8];
         rise_r    <= last_s[8] & ~en_prev_r;
         fall_r    <= ~last_s[8] & en_prev_r;
         rs_r      <= last_s[10];
         rw_r      <= last_s[9];
         data_r    <= last_s[7:0];
      end
   end

   assign rs_q    = rs_r;
   assign rw_q    = rw_r;
   assign data_q  = data_r;
   assign en_rise = rise_r;
   assign en_fall = fall_r;

endmodule

// File: rtl/lcd_cfah_responder.sv
// Device-side responder for the CFAH1602 parallel LCD bus with busy-time model.
// Optional: define LCD_CFAH_RESP_BUSY_CHECK_EN to flag writes received while busy on o_err.
module lcd_cfah_responder
   import lcd_cfah_pkg::*;
#(
   parameter int G_BUSY_CYCLES       = 2000,
   parameter int G_CLEAR_BUSY_CYCLES = 76000,
   parameter int G_SYNC_STAGES       = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_rs,
   input  logic                i_rw,
   input  logic                i_en,
   input  logic [7:0]          i_data,
   output logic [7:0]          o_data,
   output logic                o_data_oe,
   output logic [7:0]          o_instr,
   output logic                o_instr_val,
   output logic [7:0]          o_wdata,
   output logic                o_wdata_val,
   input  logic [7:0]          i_rdata,
   output logic                o_rdata_req,
   output logic [C_ADDR_W-1:0] o_addr,
   output logic                o_busy,
   output logic                o_err
);

   localparam int C_CNT_MAX = (G_CLEAR_BUSY_CYCLES > G_BUSY_CYCLES) ? G_CLEAR_BUSY_CYCLES
                                                                    : G_BUSY_CYCLES;
   localparam int C_CNT_W = $clog2(C_CNT_MAX + 1);
   localparam logic [C_CNT_W-1:0] C_LOAD_BUSY  = C_CNT_W'(G_BUSY_CYCLES);
   localparam logic [C_CNT_W-1:0] C_LOAD_CLEAR = C_CNT_W'(G_CLEAR_BUSY_CYCLES);
   localparam logic [C_CNT_W-1:0] C_CNT_ONE    = C_CNT_W'(1);

   logic               rs_s;
   logic               rw_s;
   logic [7:0]         data_s;
   logic               en_rise_s;
   logic               en_fall_s;

   state_t             state_r;
   logic [7:0]         data_r;
   logic               data_oe_r;
   logic [7:0]         instr_r;
   logic               instr_val_r;
   logic [7:0]         wdata_r;
   logic               wdata_val_r;
   logic               rdata_req_r;
   logic [C_ADDR_W-1:0] addr_r;
   logic               id_r;
   logic               busy_r;
   logic [C_CNT_W-1:0] busy_cnt_r;
   logic               read_rs_r;
   logic               wr_rs_r;
   logic [7:0]         wr_data_r;
   logic [C_CNT_W-1:0] busy_load_s;

   lcd_cfah_bus_sync #(
      .G_SYNC_STAGES(G_SYNC_STAGES)
   ) u_bus_sync (
      .clk     (clk),
      .rst     (rst),
      .rs      (i_rs),
      .rw      (i_rw),
      .en      (i_en),
      .data    (i_data),
      .rs_q    (rs_s),
      .rw_q    (rw_s),
      .data_q  (data_s),
      .en_rise (en_rise_s),
      .en_fall (en_fall_s)
   );

   // Busy reload value for the pending write: Clear and Home use the long delay.
   always_comb begin
      busy_load_s = C_LOAD_BUSY;
      if (!wr_rs_r && ((wr_data_r == C_INSTR_CLEAR) ||
                       ((wr_data_r & C_INSTR_HOME_MASK) == C_INSTR_HOME))) begin
         busy_load_s = C_LOAD_CLEAR;
      end else begin
         busy_load_s = C_LOAD_BUSY;
      end
   end

   // Bus FSM, register model and busy counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= S_IDLE;
         data_r      <= 8'h00;
         data_oe_r   <= 1'b0;
         instr_r     <= 8'h00;
         instr_val_r <= 1'b0;
         wdata_r     <= 8'h00;
         wdata_val_r <= 1'b0;
         rdata_req_r <= 1'b0;
         addr_r      <= 7'h00;
         id_r        <= 1'b1;
         busy_r      <= 1'b0;
         busy_cnt_r  <= '0;
         read_rs_r   <= 1'b0;
         wr_rs_r     <= 1'b0;
         wr_data_r   <= 8'h00;
      end else begin
         instr_val_r <= 1'b0;
         wdata_val_r <= 1'b0;
         rdata_req_r <= 1'b0;
         if (busy_cnt_r != '0) begin
            busy_cnt_r <= busy_cnt_r - C_CNT_ONE;
            busy_r     <= (busy_cnt_r != C_CNT_ONE);
         end else begin
            busy_r     <= 1'b0;
         end

         case (state_r)
            S_IDLE: begin
               if (en_rise_s && rw_s) begin
                  state_r   <= S_READ;
                  data_oe_r <= 1'b1;
                  read_rs_r <= rs_s;
                  if (rs_s) begin
                     data_r      <= i_rdata;
                     rdata_req_r <= 1'b1;
                  end else begin
                     data_r <= {busy_r, addr_r};
                  end
               end else if (en_fall_s && !rw_s) begin
                  state_r   <= S_WRITE;
                  wr_rs_r   <= rs_s;
                  wr_data_r <= data_s;
               end else begin
                  state_r <= S_IDLE;
               end
            end
            S_READ: begin
               if (en_fall_s) begin
                  state_r   <= S_IDLE;
                  data_oe_r <= 1'b0;
                  if (read_rs_r) begin
                     addr_r <= addr_step(addr_r, id_r);
                  end
               end
            end
            S_WRITE: begin
               state_r    <= S_IDLE;
               busy_cnt_r <= busy_load_s;
               busy_r     <= (busy_load_s != '0);
               if (wr_rs_r) begin
                  wdata_r     <= wr_data_r;
                  wdata_val_r <= 1'b1;
                  addr_r      <= addr_step(addr_r, id_r);
               end else begin
                  instr_r     <= wr_data_r;
                  instr_val_r <= 1'b1;
                  if (wr_data_r == C_INSTR_CLEAR) begin
                     addr_r <= 7'h00;
                     id_r   <= 1'b1;
                  end else if ((wr_data_r & C_INSTR_HOME_MASK) == C_INSTR_HOME) begin
                     addr_r <= 7'h00;
                  end else if ((wr_data_r & C_INSTR_ENTRY_MASK) == C_INSTR_ENTRY) begin
                     id_r <= wr_data_r[1];
                  end else if (wr_data_r[C_INSTR_SET_DDRAM_BIT]) begin
                     addr_r <= wr_data_r[C_ADDR_W-1:0];
                  end
               end
            end
            default: begin
               state_r <= S_IDLE;
            end
         endcase
      end
   end

`ifdef LCD_CFAH_RESP_BUSY_CHECK_EN
   logic err_r;

   // Flag a write that lands while the controller is still busy.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_r <= 1'b0;
      end else begin
         err_r <= (state_r == S_WRITE) && busy_r;
      end
   end

   assign o_err = err_r;
`else
   assign o_err = 1'b0;
`endif

   assign o_data      = data_r;
   assign o_data_oe   = data_oe_r;
   assign o_instr     = instr_r;
   assign o_instr_val = instr_val_r;
   assign o_wdata     = wdata_r;
   assign o_wdata_val = wdata_val_r;
   assign o_rdata_req = rdata_req_r;
   assign o_addr      = addr_r;
   assign o_busy      = busy_r;

endmodule

// File: tb/tb_lcd_cfah_responder.sv
// Directed self-checking bench for lcd_cfah_responder (short busy times).
module tb_lcd_cfah_responder;

   localparam int P_BUSY  = 200;
   localparam int P_CLEAR = 760;

   logic       clk = 1'b0;
   logic       rst;
   logic       i_rs;
   logic       i_rw;
   logic       i_en;
   logic [7:0] i_data;
   logic [7:0] i_rdata;
   logic [7:0] o_data;
   logic       o_data_oe;
   logic [7:0] o_instr;
   logic       o_instr_val;
   logic [7:0] o_wdata;
   logic       o_wdata_val;
   logic       o_rdata_req;
   logic [6:0] o_addr;
   logic       o_busy;
   logic       o_err;

   int total = 0;
   int bad   = 0;
   int instr_cnt = 0;
   int wdata_cnt = 0;
   int rreq_cnt  = 0;
   int err_cnt   = 0;
   int busy_hi   = 0;
   int n0;
   int b0;

   lcd_cfah_responder #(
      .G_BUSY_CYCLES       (P_BUSY),
      .G_CLEAR_BUSY_CYCLES (P_CLEAR),
      .G_SYNC_STAGES       (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_rs        (i_rs),
      .i_rw        (i_rw),
      .i_en        (i_en),
      .i_data      (i_data),
      .o_data      (o_data),
      .o_data_oe   (o_data_oe),
      .o_instr     (o_instr),
      .o_instr_val (o_instr_val),
      .o_wdata     (o_wdata),
      .o_wdata_val (o_wdata_val),
      .i_rdata     (i_rdata),
      .o_rdata_req (o_rdata_req),
      .o_addr      (o_addr),
      .o_busy      (o_busy),
      .o_err       (o_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (o_instr_val) instr_cnt++;
      if (o_wdata_val) wdata_cnt++;
      if (o_rdata_req) rreq_cnt++;
      if (o_err)       err_cnt++;
      if (o_busy)      busy_hi++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_write(input logic rs, input logic [7:0] d);
      i_rs = rs; i_rw = 1'b0; i_data = d; i_en = 1'b1;
      tick(6);
      i_en = 1'b0;
      tick(6);
   endtask

   task automatic read_start(input logic rs);
      i_rs = rs; i_rw = 1'b1; i_en = 1'b1;
      tick(6);
   endtask

   task automatic read_end();
      i_en = 1'b0;
      tick(6);
      i_rw = 1'b0;
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 2000 && o_busy; k++) tick(1);
      check("busy_timeout", 32'(o_busy), 32'h0);
   endtask

   initial begin
      rst = 1'b1; i_rs = 1'b0; i_rw = 1'b0; i_en = 1'b0; i_data = 8'h00; i_rdata = 8'h00;
      tick(3);
      rst = 1'b0;
      tick(1);
      check("rst_oe",    32'(o_data_oe), 32'h0);
      check("rst_data",  32'(o_data),    32'h00);
      check("rst_addr",  32'(o_addr),    32'h00);
      check("rst_busy",  32'(o_busy),    32'h0);
      check("rst_instr", 32'(o_instr),   32'h00);

      // Set DDRAM address 0x25
      n0 = instr_cnt; b0 = busy_hi;
      bus_write(1'b0, 8'hA5);
      check("ddram_pulse", 32'(instr_cnt - n0), 32'd1);
      check("ddram_instr", 32'(o_instr), 32'hA5);
      check("ddram_addr",  32'(o_addr),  32'h25);
      check("ddram_busy",  32'(o_busy),  32'h1);
      wait_idle();
      check("busy_len", 32'(busy_hi - b0), 32'(P_BUSY));

      // Data writes across the 0x7F -> 0x00 wrap
      bus_write(1'b0, 8'hFF);
      wait_idle();
      check("addr_7f", 32'(o_addr), 32'h7F);
      n0 = wdata_cnt;
      bus_write(1'b1, 8'h41);
      check("wdata_41", 32'(o_wdata), 32'h41);
      check("wrap_00",  32'(o_addr),  32'h00);
      bus_write(1'b1, 8'h42);
      check("wdata_42", 32'(o_wdata), 32'h42);
      check("addr_01",  32'(o_addr),  32'h01);
      check("wdata_pulses", 32'(wdata_cnt - n0), 32'd2);
      wait_idle();

      // Decrement mode wraps 0x00 -> 0x7F, then Clear
      bus_write(1'b0, 8'h04);
      wait_idle();
      bus_write(1'b0, 8'h80);
      wait_idle();
      bus_write(1'b1, 8'h33);
      check("dec_wrap_7f", 32'(o_addr), 32'h7F);
      wait_idle();
      b0 = busy_hi;
      bus_write(1'b0, 8'h01);
      check("clear_addr", 32'(o_addr), 32'h00);
      wait_idle();
      check("clear_busy_len", 32'(busy_hi - b0), 32'(P_CLEAR));
      bus_write(1'b1, 8'h55);
      check("clear_sets_inc", 32'(o_addr), 32'h01);

      // Busy-flag read while busy, then after busy expires
      read_start(1'b0);
      check("bf_oe",   32'(o_data_oe), 32'h1);
      check("bf_data", 32'(o_data),    32'h81);
      read_end();
      check("bf_oe_off", 32'(o_data_oe), 32'h0);
      check("bf_addr",   32'(o_addr),    32'h01);
      wait_idle();
      read_start(1'b0);
      check("bf_idle_data", 32'(o_data), 32'h01);
      read_end();
      check("bf_idle_addr", 32'(o_addr), 32'h01);

      // Data read
      i_rdata = 8'h5A;
      n0 = rreq_cnt;
      read_start(1'b1);
      check("rd_data", 32'(o_data), 32'h5A);
      check("rd_oe",   32'(o_data_oe), 32'h1);
      check("rd_req",  32'(rreq_cnt - n0), 32'd1);
      check("rd_addr_hold", 32'(o_addr), 32'h01);
      read_end();
      check("rd_addr_inc", 32'(o_addr), 32'h02);

      // Return Home (0x03)
      bus_write(1'b0, 8'h03);
      check("home_addr", 32'(o_addr), 32'h00);
      wait_idle();

      // Second write 100 cycles after the first
      n0 = err_cnt;
      bus_write(1'b1, 8'h11);
      tick(88);
      bus_write(1'b1, 8'h22);
`ifdef LCD_CFAH_RESP_BUSY_CHECK_EN
      check("err_pulse", 32'(err_cnt - n0), 32'd1);
`else
      check("err_tied", 32'(err_cnt - n0), 32'd0);
`endif
      check("err_write_applied", 32'(o_wdata), 32'h22);
      wait_idle();

      // Reset in the middle of a read
      read_start(1'b0);
      check("mid_oe", 32'(o_data_oe), 32'h1);
      rst = 1'b1;
      tick(1);
      check("mr_oe",    32'(o_data_oe), 32'h0);
      check("mr_data",  32'(o_data),    32'h00);
      check("mr_addr",  32'(o_addr),    32'h00);
      check("mr_instr", 32'(o_instr),   32'h00);
      check("mr_wdata", 32'(o_wdata),   32'h00);
      check("mr_busy",  32'(o_busy),    32'h0);
      i_en = 1'b0; i_rw = 1'b0;
      tick(2);
      rst = 1'b0;
      tick(6);
      check("mr_after_oe", 32'(o_data_oe), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
